// File: rtl/controle_duty_pwm.sv
// controle_duty_pwm
//  Turns the enable/direction pair coming from the button FSM into a duty-cycle
//  setpoint with press-and-hold auto-repeat, and drives a glitch-free PWM output
//  from that setpoint.
//
//  Ports:
//    clock              in   system clock, rising edge
//    reset              in   asynchronous, active-high
//    habilitar_contagem in   1 = step request active (button held)
//    modo_contagem      in   0 = increment, 1 = decrement
//    pwm                out  PWM output, registered
//    duty               out  current setpoint [LARGURA-1:0], registered
//    limite             out  registered, 1 when duty is 0 or MAX
//
//  Configuration macro: DUTY_WRAP_EN
//    defined   - a step taken while already at a limit wraps to the other limit
//    undefined - pure saturation at both limits
module controle_duty_pwm #(
  parameter int unsigned LARGURA      = 8,
  parameter int unsigned PASSO        = 16,
  parameter int unsigned REPETICAO    = 25000000,
  parameter int unsigned DUTY_INICIAL = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               habilitar_contagem,
  input  logic               modo_contagem,
  output logic               pwm,
  output logic [LARGURA-1:0] duty,
  output logic               limite
);

  localparam logic [LARGURA-1:0] MAX          = {LARGURA{1'b1}};
  localparam logic [LARGURA:0]   MAX_EXT      = {1'b0, MAX};
  localparam logic [LARGURA:0]   PASSO_EXT    = (LARGURA + 1)'(PASSO);
  localparam int unsigned        RW           = $clog2(REPETICAO);
  localparam logic [RW-1:0]      REP_RECARGA  = RW'(REPETICAO - 1);
  localparam logic [LARGURA-1:0] DUTY_RESET   = LARGURA'(DUTY_INICIAL);
  localparam logic               LIMITE_RESET = (DUTY_RESET == '0) || (DUTY_RESET == MAX);

  typedef enum logic {StParado, StRepetindo} estado_t;

  estado_t            estado;
  logic [RW-1:0]      rep;
  logic               modo_reg;
  logic [LARGURA-1:0] duty_ativo;
  logic [LARGURA-1:0] cnt;

  logic [LARGURA:0]   soma;
  logic [LARGURA:0]   diferenca;
  logic [LARGURA-1:0] duty_passo;
  logic               pedir_passo;

  // Next setpoint if a step is taken now; always in the currently requested direction.
  always_comb begin
    soma       = {1'b0, duty} + PASSO_EXT;
    diferenca  = {1'b0, duty} - PASSO_EXT;
    duty_passo = duty;
    if (!modo_contagem) begin
      if (duty == MAX) begin
`ifdef DUTY_WRAP_EN
        duty_passo = '0;
`else
        duty_passo = MAX;
`endif
      end else if (soma > MAX_EXT) begin
        duty_passo = MAX;
      end else begin
        duty_passo = soma[LARGURA-1:0];
      end
    end else begin
      if (duty == '0) begin
`ifdef DUTY_WRAP_EN
        duty_passo = MAX;
`else
        duty_passo = '0;
`endif
      end else if (diferenca[LARGURA]) begin
        // Borrow out of the extended subtraction means we went below zero.
        duty_passo = '0;
      end else begin
        duty_passo = diferenca[LARGURA-1:0];
      end
    end
  end

  // A direction change while held forces an immediate step and restarts the repeat timer.
  always_comb begin
    pedir_passo = 1'b0;
    unique case (estado)
      StParado:    pedir_passo = habilitar_contagem;
      StRepetindo: pedir_passo = habilitar_contagem &&
                                 ((modo_contagem != modo_reg) || (rep == '0));
      default:     pedir_passo = 1'b0;
    endcase
  end

  // Step FSM with registered setpoint and limit flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= StParado;
      duty     <= DUTY_RESET;
      limite   <= LIMITE_RESET;
      rep      <= '0;
      modo_reg <= 1'b0;
    end else begin
      if (pedir_passo) begin
        duty     <= duty_passo;
        limite   <= (duty_passo == '0) || (duty_passo == MAX);
        rep      <= REP_RECARGA;
        modo_reg <= modo_contagem;
      end
      unique case (estado)
        StParado: begin
          if (habilitar_contagem) estado <= StRepetindo;
        end
        StRepetindo: begin
          if (!habilitar_contagem) begin
            estado <= StParado;
          end else if (!pedir_passo) begin
            rep <= rep - 1'b1;
          end
        end
        default: estado <= StParado;
      endcase
    end
  end

  // PWM: period of MAX clocks; the setpoint is latched only at the wrap so a
  // period in progress is never disturbed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      duty_ativo <= DUTY_RESET;
      pwm        <= 1'b0;
    end else begin
      if (cnt == MAX - 1'b1) begin
        cnt        <= '0;
        duty_ativo <= duty;
      end else begin
        cnt <= cnt + 1'b1;
      end
      pwm <= (cnt < duty_ativo);
    end
  end

endmodule

// File: tb/tb_controle_duty_pwm.sv
// Testbench for controle_duty_pwm with LARGURA=4, PASSO=4, REPETICAO=3, DUTY_INICIAL=0.
// Edge index k counts rising edges since the last reset release; after edge k the
// PWM counter holds k mod 15 and pwm reflects counter value (k-1) mod 15.
module tb_controle_duty_pwm;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       hab   = 1'b0;
  logic       modo  = 1'b0;
  logic       pwm;
  logic [3:0] duty;
  logic       limite;

  int tests = 0;
  int fails = 0;
  int k     = 0;

  always #5 clock = ~clock;

  controle_duty_pwm #(
    .LARGURA     (4),
    .PASSO       (4),
    .REPETICAO   (3),
    .DUTY_INICIAL(0)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .habilitar_contagem(hab),
    .modo_contagem     (modo),
    .pwm               (pwm),
    .duty              (duty),
    .limite            (limite)
  );

  task automatic tick();
    @(posedge clock);
    #1;
    k++;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    hab = 1'b0;
    modo = 1'b0;
    reset = 1'b1;
    #3;
    tests++; if (duty !== 4'd0) begin fails++; $display("FAIL reset_duty got %0d exp 0", duty); end
    tests++; if (pwm !== 1'b0) begin fails++; $display("FAIL reset_pwm got %b exp 0", pwm); end
    tests++; if (limite !== 1'b1) begin fails++; $display("FAIL reset_limite got %b exp 1", limite); end
    reset = 1'b0;
    k = 0;
    hab = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    hab = 1'b0;
    while (k < 20) tick();
    tests++; if (duty !== 4'd8) begin fails++; $display("FAIL run_duty got %0d exp 8", duty); end
    tests++; if (pwm !== 1'b1) begin fails++; $display("FAIL run_pwm got %b exp 1", pwm); end
    #1;
    reset = 1'b1;
    #1;
    tests++; if (duty !== 4'd0) begin fails++; $display("FAIL midreset_duty got %0d exp 0", duty); end
    tests++; if (pwm !== 1'b0) begin fails++; $display("FAIL midreset_pwm got %b exp 0", pwm); end
    tests++; if (limite !== 1'b1) begin fails++; $display("FAIL midreset_limite got %b exp 1", limite); end
    #1;
    reset = 1'b0;
    k = 0;
  endtask

  task automatic test_single_step();
    logic e;
    apply_reset();
    hab = 1'b1;
    modo = 1'b0;
    tick();
    tests++; if (duty !== 4'd4) begin fails++; $display("FAIL single_duty got %0d exp 4", duty); end
    tests++; if (limite !== 1'b0) begin fails++; $display("FAIL single_limite got %b exp 0", limite); end
    hab = 1'b0;
    while (k < 45) begin
      tick();
      e = (k >= 16) && (((k - 1) % 15) < 4);
      tests++;
      if (pwm !== e) begin
        fails++; $display("FAIL single_pwm k=%0d got %b exp %b", k, pwm, e);
      end
    end
    tests++; if (duty !== 4'd4) begin fails++; $display("FAIL single_hold got %0d exp 4", duty); end
  endtask

  task automatic test_hold_up();
    int exp_d;
    apply_reset();
    hab = 1'b1;
    modo = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      exp_d = 4 * (1 + (k - 1) / 3);
      if (exp_d > 15) exp_d = 15;
      tests++;
      if (duty !== 4'(exp_d)) begin
        fails++; $display("FAIL up_duty k=%0d got %0d exp %0d", k, duty, exp_d);
      end
    end
    tests++; if (limite !== 1'b1) begin fails++; $display("FAIL up_limite got %b exp 1", limite); end
    hab = 1'b0;
    while (k < 45) begin
      tick();
      tests++;
      if (pwm !== (k >= 16)) begin
        fails++; $display("FAIL up_pwm k=%0d got %b exp %b", k, pwm, (k >= 16));
      end
    end
  endtask

  task automatic test_hold_down();
    int exp_d;
    hab = 1'b1;
    modo = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      exp_d = 15 - 4 * (1 + j / 3);
      if (exp_d < 0) exp_d = 0;
      tests++;
      if (duty !== 4'(exp_d)) begin
        fails++; $display("FAIL down_duty j=%0d got %0d exp %0d", j, duty, exp_d);
      end
    end
    hab = 1'b0;
    tests++; if (limite !== 1'b1) begin fails++; $display("FAIL down_limite got %b exp 1", limite); end
    while (k < 60) tick();
    for (int j = 0; j < 15; j++) begin
      tick();
      tests++;
      if (pwm !== 1'b0) begin fails++; $display("FAIL down_pwm k=%0d got %b exp 0", k, pwm); end
    end
    modo = 1'b0;
  endtask

  task automatic test_direction_flip();
    apply_reset();
    hab = 1'b1;
    modo = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    tests++; if (duty !== 4'd8) begin fails++; $display("FAIL flip_pre got %0d exp 8", duty); end
    modo = 1'b1;
    tick();
    tests++; if (duty !== 4'd4) begin fails++; $display("FAIL flip_t got %0d exp 4", duty); end
    tick();
    tick();
    tests++; if (duty !== 4'd4) begin fails++; $display("FAIL flip_t2 got %0d exp 4", duty); end
    tick();
    tests++; if (duty !== 4'd0) begin fails++; $display("FAIL flip_t3 got %0d exp 0", duty); end
    hab = 1'b0;
    modo = 1'b0;
  endtask

  task automatic test_mid_period();
    int  da;
    logic e;
    apply_reset();
    hab = 1'b1;
    modo = 1'b0;
    tick();
    while (k < 45) begin
      hab = (k == 20);
      tick();
      if (k == 21) begin
        tests++;
        if (duty !== 4'd8) begin fails++; $display("FAIL mid_duty got %0d exp 8", duty); end
      end
      da = (k <= 15) ? 0 : ((k <= 30) ? 4 : 8);
      e = (((k - 1) % 15) < da);
      tests++;
      if (pwm !== e) begin
        fails++; $display("FAIL mid_pwm k=%0d got %b exp %b", k, pwm, e);
      end
    end
    hab = 1'b0;
  endtask

  task automatic test_limit_step();
    apply_reset();
    hab = 1'b1;
    modo = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    tests++; if (duty !== 4'd15) begin fails++; $display("FAIL lim_top got %0d exp 15", duty); end
    hab = 1'b0;
    tick();
    hab = 1'b1;
    tick();
    hab = 1'b0;
`ifdef DUTY_WRAP_EN
    tests++; if (duty !== 4'd0) begin fails++; $display("FAIL wrap_up got %0d exp 0", duty); end
    tests++; if (limite !== 1'b1) begin fails++; $display("FAIL wrap_up_lim got %b exp 1", limite); end
    tick();
    modo = 1'b1;
    hab = 1'b1;
    tick();
    hab = 1'b0;
    tests++; if (duty !== 4'd15) begin fails++; $display("FAIL wrap_down got %0d exp 15", duty); end
`else
    tests++; if (duty !== 4'd15) begin fails++; $display("FAIL sat_up got %0d exp 15", duty); end
    tests++; if (limite !== 1'b1) begin fails++; $display("FAIL sat_up_lim got %b exp 1", limite); end
    apply_reset();
    modo = 1'b1;
    hab = 1'b1;
    tick();
    hab = 1'b0;
    tests++; if (duty !== 4'd0) begin fails++; $display("FAIL sat_down got %0d exp 0", duty); end
`endif
    tests++; if (limite !== 1'b1) begin fails++; $display("FAIL lim_flag got %b exp 1", limite); end
    tick();
    modo = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_hold_up();
    test_hold_down();
    test_direction_flip();
    test_mid_period();
    test_limit_step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
